// File: rtl/dmem_pkg.sv
// dmem_pkg: shared entry type, constants and byte-enable helper for the data-memory write buffer.
package dmem_pkg;
  localparam int DMEM_AW = 16;
  localparam logic [3:0] BE_FULL = 4'b1111;
  typedef struct packed {
    logic [DMEM_AW-3:0] addr;
    logic [31:0]        data;
    logic [3:0]         be;
  } wbuf_entry_t;
  // Both or neither partial-store flags mean a full-word store.
  function automatic logic [3:0] calc_be(input logic [1:0] ofs, input logic wl, input logic wr);
    return (wl == wr) ? BE_FULL : wl ? BE_FULL << ofs : BE_FULL >> (2'd3 - ofs);
  endfunction
endpackage

// File: rtl/wbuf_fwd.sv
// wbuf_fwd: per-lane search of the valid write-buffer entries for the youngest byte matching a load word.
module wbuf_fwd
  import dmem_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  wbuf_entry_t        i_ents [DEPTH],
  input  logic [PW-1:0]      i_head,
  input  logic [PW:0]        i_count,
  input  logic [DMEM_AW-3:0] i_addr,
  output logic [31:0]        o_data,
  output logic [3:0]         o_mask
);
  // Walk oldest to youngest so a later match overwrites an earlier one.
  always_comb begin
    o_data = '0;
    o_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ((PW+1)'(i) < i_count && i_ents[i_head + PW'(i)].addr == i_addr && i_ents[i_head + PW'(i)].be[b]) begin
          o_mask[b]       = 1'b1;
          o_data[8*b +: 8] = i_ents[i_head + PW'(i)].data[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: M-stage data-memory front end with a posted write buffer and per-byte load forwarding.
// Optional store coalescing into the youngest entry is enabled by defining DMEM_WBUF_COALESCE_EN.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = DMEM_AW
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic [AW-1:0] MemAddr,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic          WriteL,
  input  logic          WriteR,
  input  logic [31:0]   WriteData,
  output logic [31:0]   MemData,
  output logic [AW-3:0] SramAddr,
  output logic [31:0]   SramWData,
  output logic [3:0]    SramBE,
  output logic          SramWE,
  output logic          SramRE,
  input  logic          SramGnt,
  input  logic [31:0]   SramRData,
  output logic          WbufFull,
  output logic          WbufEmpty,
  output logic          Overflow
);
  localparam int PW = $clog2(DEPTH);

  wbuf_entry_t   r_buf [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [PW:0]   r_count;
  logic          r_ovf, r_ld_pend;
  logic [31:0]   r_fwd_data;
  logic [3:0]    r_fwd_mask;

  logic [AW-3:0] w_waddr;
  logic [3:0]    w_be;
  logic          w_drain, w_merge, w_enq, w_drop;
  wbuf_entry_t   w_head_ent;
  logic [31:0]   w_fwd_data;
  logic [3:0]    w_fwd_mask;

  assign w_waddr    = MemAddr[AW-1:2];
  assign w_be       = calc_be(MemAddr[1:0], WriteL, WriteR);
  assign w_head_ent = r_buf[r_head];
  assign WbufEmpty  = r_count == '0;
  assign WbufFull   = r_count == (PW+1)'(DEPTH);
  assign Overflow   = r_ovf;

  // A load owns the port; the buffer only drains on a granted non-load cycle.
  assign w_drain   = !MemRead && !WbufEmpty && SramGnt;
  assign SramRE    = MemRead;
  assign SramWE    = w_drain;
  assign SramAddr  = MemRead ? w_waddr : w_head_ent.addr;
  assign SramWData = w_head_ent.data;
  assign SramBE    = w_drain ? w_head_ent.be : 4'h0;

`ifdef DMEM_WBUF_COALESCE_EN
  logic [PW-1:0] w_young;
  wbuf_entry_t   w_mrg;
  assign w_young = r_tail - PW'(1);
  assign w_merge = MemWrite && !WbufEmpty && r_buf[w_young].addr == w_waddr && !(w_drain && w_young == r_head);
  always_comb begin
    w_mrg    = r_buf[w_young];
    w_mrg.be = w_mrg.be | w_be;
    for (int b = 0; b < 4; b++)
      w_mrg.data[8*b +: 8] = w_be[b] ? WriteData[8*b +: 8] : w_mrg.data[8*b +: 8];
  end
`else
  assign w_merge = 1'b0;
`endif

  assign w_enq  = MemWrite && !w_merge && (!WbufFull || w_drain);
  assign w_drop = MemWrite && !w_merge && WbufFull && !w_drain;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_drain) r_head <= r_head + PW'(1);
      if (w_enq) r_tail <= r_tail + PW'(1);
      r_count <= r_count + (PW+1)'(w_enq) - (PW+1)'(w_drain);
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Entry payload needs no reset: validity comes solely from head/count.
  always_ff @(posedge Clock) begin
    if (w_enq) r_buf[r_tail] <= '{addr: w_waddr, data: WriteData, be: w_be};
`ifdef DMEM_WBUF_COALESCE_EN
    else if (w_merge) r_buf[w_young] <= w_mrg;
`endif
  end

  wbuf_fwd #(.DEPTH(DEPTH)) u_fwd (
    .i_ents  (r_buf),
    .i_head  (r_head),
    .i_count (r_count),
    .i_addr  (w_waddr),
    .o_data  (w_fwd_data),
    .o_mask  (w_fwd_mask)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_ld_pend  <= 1'b0;
      r_fwd_mask <= '0;
      r_fwd_data <= '0;
    end else begin
      r_ld_pend  <= MemRead;
      r_fwd_mask <= MemRead ? w_fwd_mask : 4'h0;
      r_fwd_data <= w_fwd_data;
    end
  end

  always_comb begin
    MemData = '0;
    for (int b = 0; b < 4; b++)
      MemData[8*b +: 8] = !r_ld_pend ? 8'h00 : r_fwd_mask[b] ? r_fwd_data[8*b +: 8] : SramRData[8*b +: 8];
  end
endmodule

// File: tb/tb_dmem_wbuf.sv
// tb_dmem_wbuf: directed and random stimulus checked against a queue-based write-buffer model.
module tb_dmem_wbuf;
  localparam int DEPTH = 4;

  logic        Clock = 1'b0;
  logic        nReset;
  logic [15:0] MemAddr;
  logic        MemRead, MemWrite, WriteL, WriteR, SramGnt, SramWE, SramRE;
  logic [31:0] WriteData, MemData, SramWData, SramRData;
  logic [13:0] SramAddr;
  logic [3:0]  SramBE;
  logic        WbufFull, WbufEmpty, Overflow;

  typedef struct {
    logic [13:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t        q[$];
  bit          ovf;
  logic [31:0] sram    [16384];
  logic [31:0] ref_mem [16384];
  logic [31:0] md;
  int          n_tests = 0;
  int          n_fail  = 0;

  dmem_wbuf #(.DEPTH(DEPTH), .AW(16)) dut (
    .Clock(Clock), .nReset(nReset), .MemAddr(MemAddr), .MemRead(MemRead), .MemWrite(MemWrite),
    .WriteL(WriteL), .WriteR(WriteR), .WriteData(WriteData), .MemData(MemData),
    .SramAddr(SramAddr), .SramWData(SramWData), .SramBE(SramBE), .SramWE(SramWE), .SramRE(SramRE),
    .SramGnt(SramGnt), .SramRData(SramRData), .WbufFull(WbufFull), .WbufEmpty(WbufEmpty),
    .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (SramWE)
      for (int b = 0; b < 4; b++)
        if (SramBE[b]) sram[SramAddr][8*b +: 8] <= SramWData[8*b +: 8];
    if (SramRE) SramRData <= sram[SramAddr];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step(input bit rd, input bit wr, input logic [15:0] a, input bit l, input bit r,
                      input logic [31:0] d, input bit g);
    logic [13:0] w;
    logic [3:0]  be;
    logic [31:0] exp_md;
    bit          drain, merge;
    ent_t        e;
    MemRead = rd; MemWrite = wr; MemAddr = a; WriteL = l; WriteR = r; WriteData = d; SramGnt = g;
    #1;
    w = a[15:2];
    drain = !rd && q.size() != 0 && g;
    chk("sram_we", 32'(SramWE), 32'(drain));
    chk("sram_re", 32'(SramRE), 32'(rd));
    chk("full", 32'(WbufFull), 32'(q.size() == DEPTH));
    chk("empty", 32'(WbufEmpty), 32'(q.size() == 0));
    chk("overflow", 32'(Overflow), 32'(ovf));
    if (drain) begin
      chk("wr_addr", 32'(SramAddr), 32'(q[0].a));
      chk("wr_data", SramWData, q[0].d);
      chk("wr_be", 32'(SramBE), 32'(q[0].be));
    end
    if (rd) chk("rd_addr", 32'(SramAddr), 32'(w));
    exp_md = 32'h0;
    if (rd) begin
      exp_md = ref_mem[w];
      foreach (q[i])
        if (q[i].a == w)
          for (int b = 0; b < 4; b++)
            if (q[i].be[b]) exp_md[8*b +: 8] = q[i].d[8*b +: 8];
    end
    for (int b = 0; b < 4; b++)
      be[b] = (l && !r) ? (b >= int'(a[1:0])) : (r && !l) ? (b <= int'(a[1:0])) : 1'b1;
    merge = 1'b0;
`ifdef DMEM_WBUF_COALESCE_EN
    merge = wr && q.size() != 0 && q[q.size()-1].a == w && !(drain && q.size() == 1);
`endif
    if (drain) begin
      for (int b = 0; b < 4; b++)
        if (q[0].be[b]) ref_mem[q[0].a][8*b +: 8] = q[0].d[8*b +: 8];
      void'(q.pop_front());
    end
    if (wr) begin
      if (merge) begin
        e = q[q.size()-1];
        for (int b = 0; b < 4; b++)
          if (be[b]) e.d[8*b +: 8] = d[8*b +: 8];
        e.be = e.be | be;
        q[q.size()-1] = e;
      end else if (q.size() < DEPTH) q.push_back('{a: w, d: d, be: be});
      else ovf = 1'b1;
    end
    @(posedge Clock);
    #1;
    md = MemData;
    chk("mem_data", md, exp_md);
    @(negedge Clock);
  endtask

  task automatic idle(input bit g);
    step(0, 0, 16'h0, 0, 0, 32'h0, g);
  endtask

  task automatic do_reset();
    MemRead = 0; MemWrite = 0; SramGnt = 1;
    #1 nReset = 0;
    #1;
    q.delete();
    ovf = 1'b0;
    chk("rst_empty", 32'(WbufEmpty), 32'd1);
    chk("rst_full", 32'(WbufFull), 32'd0);
    chk("rst_ovf", 32'(Overflow), 32'd0);
    chk("rst_we", 32'(SramWE), 32'd0);
    chk("rst_md", MemData, 32'h0);
    @(posedge Clock);
    @(negedge Clock);
    nReset = 1;
  endtask

  initial begin
    nReset = 0; MemAddr = 0; MemRead = 0; MemWrite = 0; WriteL = 0; WriteR = 0;
    WriteData = 0; SramGnt = 0; SramRData = 0; ovf = 0;
    for (int i = 0; i < 16384; i++) begin
      sram[i]    = $urandom;
      ref_mem[i] = sram[i];
    end
    sram[16]    = 32'h11223344;
    ref_mem[16] = 32'h11223344;
    repeat (2) @(negedge Clock);
    chk("init_empty", 32'(WbufEmpty), 32'd1);
    chk("init_md", MemData, 32'h0);
    nReset = 1;
    // Held store forwarded in full to a following load.
    step(0, 1, 16'h0020, 0, 0, 32'hAABBCCDD, 0);
    step(1, 0, 16'h0020, 0, 0, 32'h0, 0);
    chk("fwd_full", md, 32'hAABBCCDD);
    // Right partial store merges with SRAM bytes on load.
    step(0, 1, 16'h0041, 0, 1, 32'h0000EEFF, 0);
    step(1, 0, 16'h0040, 0, 0, 32'h0, 0);
    chk("fwd_partial", md, 32'h1122EEFF);
    // Loads hold off the drain even with grant.
    repeat (3) step(1, 0, 16'h0044, 0, 0, 32'h0, 1);
    repeat (3) idle(1);
    chk("drained", 32'(WbufEmpty), 32'd1);
    // Fill, overflow, then drain in order.
    for (int i = 0; i < 4; i++) step(0, 1, 16'(16'h0010 + 4*i), 0, 0, $urandom, 0);
    chk("full4", 32'(WbufFull), 32'd1);
    step(0, 1, 16'h0030, 0, 0, 32'h12345678, 0);
    chk("ovf5", 32'(Overflow), 32'd1);
    chk("full5", 32'(WbufFull), 32'd1);
    step(0, 1, 16'h0034, 0, 0, 32'h0BADF00D, 1);
    repeat (5) idle(1);
    chk("empty_after", 32'(WbufEmpty), 32'd1);
    // Reset while stores are pending and a drain is granted.
    step(0, 1, 16'h0024, 0, 0, 32'hDEADBEEF, 0);
    step(0, 1, 16'h0028, 0, 0, 32'hCAFEF00D, 0);
    do_reset();
    repeat (2) idle(1);
    chk("rst_no_write", sram[9], ref_mem[9]);
`ifdef DMEM_WBUF_COALESCE_EN
    step(0, 1, 16'h0062, 1, 0, 32'hAABB0000, 0);
    step(0, 1, 16'h0061, 0, 1, 32'h0000CCDD, 0);
    idle(1);
    chk("coal_single", 32'(WbufEmpty), 32'd1);
    chk("coal_word", sram[24], 32'hAABBCCDD);
`endif
    for (int n = 0; n < 400; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (n == 200) do_reset();
      step(op < 3, op >= 3 && op < 7, {10'h0, 4'($urandom_range(0, 7)), 2'($urandom)},
           1'($urandom), 1'($urandom), $urandom, 1'($urandom));
    end
    repeat (6) idle(1);
    for (int i = 0; i < 16; i++) chk("final_mem", sram[i], ref_mem[i]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_wbuf.md
Name: dmem_wbuf

Overview:
- Data-memory front end directly downstream of the processor's M stage.
- Accepts M-stage loads and stores (MemAddr, MemRead, MemWrite, WriteL, WriteR, WriteData) and returns MemData to the W stage with fixed 1-cycle latency.
- Stores go into a small posted write buffer that drains to a shared single-port synchronous SRAM whenever the port is free and granted.
- Loads bypass the buffer to the SRAM; pending buffered bytes are forwarded into load data per byte, newest entry wins.

Parameters:
- DEPTH, 4, write-buffer entries; power of two, >= 2.
- AW, 16, processor byte-address width. SRAM word address width is AW-2.

Ports:
- Clock  in  1  system clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- MemAddr  in  AW  byte address from M stage.
- MemRead  in  1  load in M this cycle.
- MemWrite  in  1  store in M this cycle; never high together with MemRead.
- WriteL  in  1  left partial store.
- WriteR  in  1  right partial store.
- WriteData  in  32  store data, already lane-aligned.
- MemData  out  32  load data, valid the cycle after MemRead.
- SramAddr  out  AW-2  SRAM word address.
- SramWData  out  32  SRAM write data.
- SramBE  out  4  SRAM byte enables.
- SramWE  out  1  SRAM write strobe.
- SramRE  out  1  SRAM read strobe.
- SramGnt  in  1  external arbiter permits a write this cycle; reads are always permitted.
- SramRData  in  32  SRAM read data, one cycle after SramRE.
- WbufFull  out  1  occupancy == DEPTH; integration ORs this into the stall request.
- WbufEmpty  out  1  occupancy == 0.
- Overflow  out  1  sticky: a store was dropped.

Behaviour:
- Reset (async, nReset low):
  - Buffer empty, head/tail/count = 0.
  - WbufEmpty=1; WbufFull=0; Overflow=0.
  - SramWE=0; SramRE=0; load-pending=0; MemData=0.
  - A reset mid-drain abandons buffered stores without a write.
- Byte enables, ofs = MemAddr[1:0]:
  - Neither WriteL nor WriteR: BE=4'b1111.
  - WriteL: BE = 4'b1111<<ofs, i.e. bytes ofs..3.
  - WriteR: BE = 4'b1111>>(3-ofs), i.e. bytes 0..ofs.
  - Both high: treated as a full word.
- Entry contents: {word address MemAddr[AW-1:2], data, BE}.
- SRAM port priority: load read > buffer drain > idle.
  - Load cycle: SramRE=1, SramAddr = load word address, no drain.
  - Otherwise, if the buffer is non-empty and SramGnt=1: SramWE=1 with the head entry's address, data and BE; head advances at the clock edge.
  - If SramGnt=0: head is held and SramWE=0.
- Enqueue: a store is written at tail on the clock edge.
  - Buffer full but a drain occurs the same cycle: store accepted, count unchanged.
  - Buffer full and no drain: store dropped, Overflow set until reset.
- Count: +1 on enqueue only, -1 on drain only, unchanged on both. Pointers wrap modulo DEPTH.
- Load forwarding (evaluated in the M cycle):
  - For each byte lane, select the youngest valid entry whose word address matches and whose BE bit is set.
  - Register the forward data and a 4-bit forward mask.
  - Next cycle, per lane: MemData = mask ? fwd : SramRData.
  - No load pending: MemData=0.
- Store then load to the same word on consecutive cycles: the load must see the store's bytes.
- An entry draining in the same cycle as a load cannot occur, because loads block drains.
- Latency: store visible in SRAM at best 1 cycle after enqueue; load data always 1 cycle after MemRead.

Optional Feature:
- DMEM_WBUF_COALESCE_EN defined:
  - A store whose word address equals the tail-1 (youngest) entry merges into that entry: BE OR'd, new bytes overwrite. No new entry is allocated.
  - Applies only if that entry is not the head draining this cycle.
  - A merged store never overflows.
- Undefined: every store allocates a new entry.

Decomposition:
- Package dmem_pkg:
  - typedef wbuf_entry_t {logic [AW-3:0] addr; logic [31:0] data; logic [3:0] be;}
  - Constants BE_FULL=4'b1111.
  - Function calc_be(ofs, WriteL, WriteR).
- Sub-module wbuf_fwd: combinational per-lane youngest-match search over DEPTH entries, returning fwd data and mask.

Test Plan:
- Reset with stores pending -> WbufEmpty=1, MemData=0, no SramWE after reset release.
- SramGnt=0; 4 stores to 0x0010,0x0014,0x0018,0x001C -> WbufFull=1. 5th store -> Overflow=1, count stays 4. SramGnt=1 -> 4 writes in order, WbufEmpty=1.
- Store 0xAABBCCDD to 0x0020 with SramGnt=0, then load 0x0020 -> MemData=0xAABBCCDD regardless of SramRData.
- SRAM word 0x11223344 at 0x0040; WriteR at ofs=1 with data 0x0000EEFF, held; load -> MemData=0x1122EEFF (BE=0011).
- Load every cycle while buffer non-empty and SramGnt=1 -> no SramWE until MemRead drops, then drain resumes.
- COALESCE_EN: two WriteL/WriteR stores to the same word -> single entry, BE=1111, one SramWE.
